// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and constants for the vector instruction sequencer
package vec_pkg;
    localparam int VLEN           = 32;
    localparam int ELEMS_PER_BEAT = 4;

    typedef enum logic [1:0] {
        SEW8     = 2'd0,
        SEW16    = 2'd1,
        SEW32    = 2'd2,
        SEW_RSVD = 2'd3
    } vsew_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    // Register-group size for an LMUL encoding (1, 2, 4 or 8 registers).
    function automatic logic [3:0] lmul_regs(input logic [1:0] vlmul);
        return 4'd1 << vlmul;
    endfunction
endpackage

// File: rtl/vec_cfg_check.sv
// rtl/vec_cfg_check.sv - combinational legality check of a vector instruction configuration
module vec_cfg_check
    import vec_pkg::*;
(
    input  logic [5:0] vl,
    input  logic [1:0] vsew,
    input  logic [1:0] vlmul,
    input  logic       widening,
    input  logic [4:0] vs1_base,
    input  logic [4:0] vs2_base,
    input  logic [4:0] vd_base,
    output logic       legal
);
    vsew_e      sew;
    logic [3:0] lmul;
    logic [4:0] grp_mask;
    logic [4:0] wide_mask;
    logic [6:0] vlmax;
    logic       vd_ok;

    always_comb begin
        sew       = vsew_e'(vsew);
        lmul      = lmul_regs(vlmul);
        grp_mask  = {1'b0, lmul} - 5'd1;
        wide_mask = {lmul, 1'b0} - 5'd1;
        // VLMAX = (4 >> vsew) * LMUL, written as a left shift of LMUL
        vlmax     = (sew == SEW_RSVD) ? 7'd0 : (7'({3'b000, lmul}) << (2'd2 - vsew));
        if (widening) begin
            vd_ok = (sew == SEW8 || sew == SEW16) && (vlmul != 2'd3) && ((vd_base & wide_mask) == 5'd0);
        end else begin
            vd_ok = (vd_base & grp_mask) == 5'd0;
        end
        legal = (sew != SEW_RSVD) && ({1'b0, vl} <= vlmax)
              && ((vs1_base & grp_mask) == 5'd0) && ((vs2_base & grp_mask) == 5'd0)
              && (vd_base != 5'd0) && vd_ok;
    end
endmodule

// File: rtl/vector_op_sequencer.sv
// rtl/vector_op_sequencer.sv - issues one vector instruction as ceil(vl/4) beats to the regfile and PEs
module vector_op_sequencer
    import vec_pkg::*;
#(
    parameter int PE_LATENCY = 2
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start,
    output logic       ready,
    input  logic [5:0] vl,
    input  logic [1:0] vsew,
    input  logic [1:0] vlmul,
    input  logic       widening,
    input  logic [4:0] vs1_base,
    input  logic [4:0] vs2_base,
    input  logic [4:0] vd_base,
    input  logic       pe_stall,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [4:0] vs1_addr,
    output logic [4:0] vs2_addr,
    output logic [4:0] vd_addr,
    output logic [1:0] vsew_o,
    output logic       widening_op,
    output logic [1:0] elements_to_write,
    output logic       write,
    output logic       pe_start
);
    localparam logic [7:0] CNT_LAST = 8'(PE_LATENCY - 1);

    seq_state_e state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] vs1_addr_q, vs1_addr_d;
    logic [4:0] vs2_addr_q, vs2_addr_d;
    logic [4:0] vd_addr_q, vd_addr_d;
    logic [1:0] vsew_q, vsew_d;
    logic       wid_q, wid_d;
    logic       illegal_q, illegal_d;
    logic       legal;
    logic       accept;
    logic [4:0] src_step;
    logic [4:0] vd_step;

    vec_cfg_check u_cfg_check (
        .vl       (vl),
        .vsew     (vsew),
        .vlmul    (vlmul),
        .widening (widening),
        .vs1_base (vs1_base),
        .vs2_base (vs2_base),
        .vd_base  (vd_base),
        .legal    (legal)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        vs1_addr_d = vs1_addr_q;
        vs2_addr_d = vs2_addr_q;
        vd_addr_d  = vd_addr_q;
        vsew_d     = vsew_q;
        wid_d      = wid_q;
        accept     = start && (state_q == S_IDLE);
        illegal_d  = accept && !legal;
        // Base-relative stepping keeps each beat on the group alignment the regfile expects
        src_step   = 5'd1 << vsew_q;
        vd_step    = wid_q ? (src_step << 1) : src_step;

        case (state_q)
            S_IDLE: begin
                if (accept && legal) begin
                    rem_d      = vl;
                    vs1_addr_d = vs1_base;
                    vs2_addr_d = vs2_base;
                    vd_addr_d  = vd_base;
                    vsew_d     = vsew;
                    wid_d      = widening;
                    state_d    = (vl == 6'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!pe_stall) begin
                    if (cnt_q == CNT_LAST) state_d = S_WB;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                if (rem_q > 6'd4) begin
                    rem_d      = rem_q - 6'd4;
                    vs1_addr_d = vs1_addr_q + src_step;
                    vs2_addr_d = vs2_addr_q + src_step;
                    vd_addr_d  = vd_addr_q + vd_step;
                    state_d    = S_ISSUE;
                end else begin
                    rem_d   = 6'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            rem_q      <= 6'd0;
            cnt_q      <= 8'd0;
            vs1_addr_q <= 5'd0;
            vs2_addr_q <= 5'd0;
            vd_addr_q  <= 5'd0;
            vsew_q     <= 2'd0;
            wid_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            vs1_addr_q <= vs1_addr_d;
            vs2_addr_q <= vs2_addr_d;
            vd_addr_q  <= vd_addr_d;
            vsew_q     <= vsew_d;
            wid_q      <= wid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ready             = (state_q == S_IDLE);
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign write             = (state_q == S_WB);
    assign pe_start          = (state_q == S_ISSUE);
    assign illegal           = illegal_q;
    assign vs1_addr          = vs1_addr_q;
    assign vs2_addr          = vs2_addr_q;
    assign vd_addr           = vd_addr_q;
    assign vsew_o            = vsew_q;
    assign widening_op       = wid_q;
    assign elements_to_write = (rem_q >= 6'd4) ? 2'd0 : rem_q[1:0];
endmodule

// File: tb/tb_vector_op_sequencer.sv
// tb/tb_vector_op_sequencer.sv - scoreboard bench for vector_op_sequencer
module tb_vector_op_sequencer;
    localparam int PL = 2;
    localparam int EV_WR = 0, EV_DONE = 1, EV_ILL = 2;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       start, widening, pe_stall;
    logic [5:0] vl;
    logic [1:0] vsew, vlmul;
    logic [4:0] vs1_base, vs2_base, vd_base;
    logic       ready, busy, done, illegal, widening_op, write, pe_start;
    logic [4:0] vs1_addr, vs2_addr, vd_addr;
    logic [1:0] vsew_o, elements_to_write;

    typedef struct {
        int         kind;
        logic [4:0] a1, a2, ad;
        logic [1:0] ete, sew;
        logic       wid;
    } ev_t;

    ev_t q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  t0;

    vector_op_sequencer #(.PE_LATENCY(PL)) dut (
        .clk (clk), .n_reset (n_reset), .start (start), .ready (ready),
        .vl (vl), .vsew (vsew), .vlmul (vlmul), .widening (widening),
        .vs1_base (vs1_base), .vs2_base (vs2_base), .vd_base (vd_base),
        .pe_stall (pe_stall), .busy (busy), .done (done), .illegal (illegal),
        .vs1_addr (vs1_addr), .vs2_addr (vs2_addr), .vd_addr (vd_addr),
        .vsew_o (vsew_o), .widening_op (widening_op),
        .elements_to_write (elements_to_write), .write (write), .pe_start (pe_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a1, a2, ad, input logic [1:0] ete, sew, input logic wid);
        ev_t e;
        e.kind = EV_WR; e.a1 = a1; e.a2 = a2; e.ad = ad; e.ete = ete; e.sew = sew; e.wid = wid;
        q.push_back(e);
    endtask

    task automatic exp_ev(input int kind);
        ev_t e;
        e.kind = kind; e.a1 = '0; e.a2 = '0; e.ad = '0; e.ete = '0; e.sew = '0; e.wid = 1'b0;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            check("unexpected_event", kind, -1);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_WR && e.kind == EV_WR) begin
                check("wb_vs1_addr", int'(vs1_addr), int'(e.a1));
                check("wb_vs2_addr", int'(vs2_addr), int'(e.a2));
                check("wb_vd_addr", int'(vd_addr), int'(e.ad));
                check("wb_ete", int'(elements_to_write), int'(e.ete));
                check("wb_vsew_o", int'(vsew_o), int'(e.sew));
                check("wb_widening_op", int'(widening_op), int'(e.wid));
                check("wb_busy", int'(busy), 1);
            end
        end
    endtask

    // Monitor: pe_start peeks at the next expected write, write/done/illegal consume events
    always @(negedge clk) begin
        if (n_reset) begin
            if (pe_start) begin
                if (q.size() == 0 || q[0].kind != EV_WR) begin
                    check("unexpected_pe_start", 1, 0);
                end else begin
                    check("issue_vs1_addr", int'(vs1_addr), int'(q[0].a1));
                    check("issue_vs2_addr", int'(vs2_addr), int'(q[0].a2));
                    check("issue_vd_addr", int'(vd_addr), int'(q[0].ad));
                end
            end
            if (write)   pop_cmp(EV_WR);
            if (done)    pop_cmp(EV_DONE);
            if (illegal) pop_cmp(EV_ILL);
        end
    end

    task automatic issue(input logic [5:0] l, input logic [1:0] sew, lmul, input logic w,
                         input logic [4:0] a1, a2, ad, output int t_acc);
        @(negedge clk);
        vl = l; vsew = sew; vlmul = lmul; widening = w;
        vs1_base = a1; vs2_base = a2; vd_base = ad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(input int t_acc, input int exp_lat, input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(name, -1, exp_lat);
        else          check(name, cyc - t_acc, exp_lat);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_illegal"}, int'(illegal), 0);
        check({tag, "_write"}, int'(write), 0);
        check({tag, "_pe_start"}, int'(pe_start), 0);
        check({tag, "_addrs"}, int'({vs1_addr, vs2_addr, vd_addr}), 0);
        check({tag, "_cfg"}, int'({vsew_o, widening_op, elements_to_write}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0; start = 1'b0; pe_stall = 1'b0; widening = 1'b0;
        vl = '0; vsew = '0; vlmul = '0; vs1_base = '0; vs2_base = '0; vd_base = '0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        n_reset = 1'b1;

        // T1: one full beat
        exp_wr(5'd4, 5'd8, 5'd12, 2'd0, 2'd0, 1'b0); exp_ev(EV_DONE);
        issue(6'd4, 2'd0, 2'd0, 1'b0, 5'd4, 5'd8, 5'd12, t0);
        wait_done(t0, 4, "t1_latency");

        // T2: two beats, partial tail; a start while busy must be ignored
        exp_wr(5'd0, 5'd4, 5'd16, 2'd0, 2'd1, 1'b0);
        exp_wr(5'd2, 5'd6, 5'd18, 2'd3, 2'd1, 1'b0); exp_ev(EV_DONE);
        issue(6'd7, 2'd1, 2'd2, 1'b0, 5'd0, 5'd4, 5'd16, t0);
        @(negedge clk);
        vd_base = 5'd20; vl = 6'd4; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(t0, 8, "t2_latency");

        // T3: 32-bit elements, LMUL 8
        exp_wr(5'd8, 5'd16, 5'd24, 2'd0, 2'd2, 1'b0);
        exp_wr(5'd12, 5'd20, 5'd28, 2'd0, 2'd2, 1'b0); exp_ev(EV_DONE);
        issue(6'd8, 2'd2, 2'd3, 1'b0, 5'd8, 5'd16, 5'd24, t0);
        wait_done(t0, 8, "t3_latency");

        // T4: widening, vd steps twice the source step
        exp_wr(5'd0, 5'd2, 5'd4, 2'd0, 2'd0, 1'b1);
        exp_wr(5'd1, 5'd3, 5'd6, 2'd0, 2'd0, 1'b1); exp_ev(EV_DONE);
        issue(6'd8, 2'd0, 2'd1, 1'b1, 5'd0, 5'd2, 5'd4, t0);
        wait_done(t0, 8, "t4_latency");

        // Illegal configurations: widening vd misaligned, widening at 32b, vl>VLMAX, vd=0
        exp_ev(EV_ILL);
        issue(6'd4, 2'd0, 2'd1, 1'b1, 5'd0, 5'd2, 5'd2, t0);
        check("ill_vd_ready", int'(ready), 1);
        check("ill_vd_busy", int'(busy), 0);
        exp_ev(EV_ILL);
        issue(6'd1, 2'd2, 2'd0, 1'b1, 5'd0, 5'd0, 5'd4, t0);
        check("ill_sew_ready", int'(ready), 1);
        exp_ev(EV_ILL);
        issue(6'd5, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd4, t0);
        check("ill_vl_ready", int'(ready), 1);
        exp_ev(EV_ILL);
        issue(6'd4, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd0, t0);
        check("ill_vd0_ready", int'(ready), 1);

        // T5: vl=0 finishes immediately with no write
        exp_ev(EV_DONE);
        issue(6'd0, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd4, t0);
        wait_done(t0, 0, "vl0_latency");

        // Single-element beat
        exp_wr(5'd1, 5'd2, 5'd3, 2'd1, 2'd0, 1'b0); exp_ev(EV_DONE);
        issue(6'd1, 2'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, t0);
        wait_done(t0, 4, "vl1_latency");

        // T6: three stalled EXEC cycles delay write-back by three
        exp_wr(5'd4, 5'd8, 5'd12, 2'd0, 2'd0, 1'b0); exp_ev(EV_DONE);
        issue(6'd4, 2'd0, 2'd0, 1'b0, 5'd4, 5'd8, 5'd12, t0);
        @(negedge clk);
        pe_stall = 1'b1;
        repeat (3) @(negedge clk);
        pe_stall = 1'b0;
        wait_done(t0, 7, "stall_latency");

        // T6: asynchronous reset in EXEC
        exp_wr(5'd4, 5'd8, 5'd12, 2'd0, 2'd0, 1'b0); exp_ev(EV_DONE);
        issue(6'd4, 2'd0, 2'd0, 1'b0, 5'd4, 5'd8, 5'd12, t0);
        @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        n_reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        q.delete();
        @(negedge clk);
        n_reset = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_ready", int'(ready), 1);

        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
